arith_regs: RTL and testbench

Arithmetic register file (МАУ datapath) that executes the one-cycle micro-operation strobes issued by the local program sensor `arith_ctrl`. It holds working registers A, B, C and the multiplier register D, and performs ones'-complement add, AND, shifts and inter-register moves. It returns the status bits the sensor branches on. It sits between `arith_ctrl`, memory read data and the arithmetic-result path.

---
 rtl/arith_regs_pkg.sv | 9 +
 rtl/arith_regs_oc_adder.sv | 15 +
 rtl/arith_regs.sv | 97 +++++++++
 tb/tb_arith_regs.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_regs_pkg.sv
// arith_regs_pkg: shared word constants and a writer-count helper for the arithmetic datapath
package arith_regs_pkg;
    localparam int WORD_W   = 31;
    localparam int SIGN_BIT = 0;
    localparam int LSB_BIT  = WORD_W - 1;
    function automatic logic multi(input logic [7:0] v);
        return |(v & (v - 8'd1));
    endfunction
endpackage

// File: rtl/arith_regs_oc_adder.sv
// oc_adder: W-bit ones'-complement adder with end-around carry (combinational)
// Ports: a, b (W) operands; sum (W) result, -0 (all ones) kept as is.
module oc_adder
    import arith_regs_pkg::*;
#(
    parameter int W = WORD_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);
    logic [W:0] raw;
    assign raw = {1'b0, a} + {1'b0, b};
    assign sum = raw[W-1:0] + {{(W-1){1'b0}}, raw[W]};
endmodule

// File: rtl/arith_regs.sv
// arith_regs: A/B/C/D register file executing one-cycle micro-op strobes from arith_ctrl
// Ports: clk, resetn (sync, active-low); do_* strobes with reg_*_sign, mem_rdata, arr_c_data;
// reg_a..reg_d register contents; reg_b_0, reg_c_30, reg_d_0 status bits; op_conflict sticky.
// Word bit 0 (sign) is vector index W-1; word bit W-1 (LSB) is vector index 0.
module arith_regs
    import arith_regs_pkg::*;
#(
    parameter int W = WORD_W
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         do_clear_a,
    input  logic         do_clear_b,
    input  logic         do_clear_c,
    input  logic         reg_a_sign,
    input  logic         reg_b_sign,
    input  logic         reg_c_sign,
    input  logic         do_not_a,
    input  logic         do_not_b,
    input  logic         do_sum,
    input  logic         do_and,
    input  logic         do_set_c_30,
    input  logic         do_left_shift_b,
    input  logic         do_left_shift_c,
    input  logic         do_left_shift_c29,
    input  logic         do_right_shift_bc,
    input  logic         do_move_c_to_a,
    input  logic         do_move_c_to_b,
    input  logic         do_move_b_to_c,
    input  logic         do_read_mem,
    input  logic [W-1:0] mem_rdata,
    input  logic         do_arr_c,
    input  logic [W-1:0] arr_c_data,
    input  logic         do_load_d,
    output logic [W-1:0] reg_a,
    output logic [W-1:0] reg_b,
    output logic [W-1:0] reg_c,
    output logic [W-1:0] reg_d,
    output logic         reg_b_0,
    output logic         reg_c_30,
    output logic         reg_d_0,
    output logic         op_conflict
);
    localparam int S = W - 1 - SIGN_BIT;
    localparam int L = W - 1 - LSB_BIT;
    logic [W-1:0] sum_ab, b_lsh, c_lsh, b_rsh, c_rsh, a_n, b_n, c_base, c_n;
    logic         conflict;
    oc_adder #(.W(W)) u_add (.a(reg_a), .b(reg_b), .sum(sum_ab));
    // Magnitude shifts keep the sign; left3 rotates old C bit 1 into the LSB.
    assign b_lsh = {reg_b[W-1], reg_b[W-3:0], 1'b0};
    assign c_lsh = {reg_c[W-1], reg_c[W-3:0], do_left_shift_c29 & reg_c[W-2]};
    assign b_rsh = {reg_b[W-1], 1'b0, reg_b[W-2:1]};
    assign c_rsh = {reg_c[W-1], reg_b[0], reg_c[W-2:1]};
    always_comb begin
        a_n = do_move_c_to_a ? reg_c :
              do_not_a       ? ~reg_a :
              do_clear_a     ? {reg_a_sign, {(W-1){1'b0}}} : reg_a;
        b_n = do_read_mem       ? mem_rdata :
              do_move_c_to_b    ? reg_c :
              do_right_shift_bc ? b_rsh :
              do_left_shift_b   ? b_lsh :
              do_not_b          ? ~reg_b :
              do_clear_b        ? {reg_b_sign, {(W-1){1'b0}}} : reg_b;
        c_base = do_arr_c          ? arr_c_data :
                 do_sum            ? sum_ab :
                 do_and            ? reg_a & reg_b :
                 do_move_b_to_c    ? reg_b :
                 do_right_shift_bc ? c_rsh :
                 do_left_shift_c   ? c_lsh :
                 do_clear_c        ? {reg_c_sign, {(W-1){1'b0}}} : reg_c;
        // set_c_30 layers on top of whichever C writer won; it is never a conflict
        c_n = c_base | {{(W-1){1'b0}}, do_set_c_30};
        conflict = multi({5'b0, do_move_c_to_a, do_not_a, do_clear_a}) |
                   multi({2'b0, do_read_mem, do_move_c_to_b, do_right_shift_bc,
                          do_left_shift_b, do_not_b, do_clear_b}) |
                   multi({1'b0, do_arr_c, do_sum, do_and, do_move_b_to_c,
                          do_right_shift_bc, do_left_shift_c, do_clear_c});
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            reg_a       <= '0;
            reg_b       <= '0;
            reg_c       <= '0;
            reg_d       <= '0;
            op_conflict <= 1'b0;
        end else begin
            reg_a       <= a_n;
            reg_b       <= b_n;
            reg_c       <= c_n;
            reg_d       <= do_load_d ? mem_rdata : reg_d;
            op_conflict <= op_conflict | conflict;
        end
    end
    assign reg_b_0  = reg_b[S];
    assign reg_c_30 = reg_c[L];
    assign reg_d_0  = reg_d[S];
endmodule

// File: tb/tb_arith_regs.sv
// tb_arith_regs: randomized and directed self-checking bench for arith_regs
module tb_arith_regs;
    localparam int W = 31;
    localparam logic [W-1:0] MASK = 31'h3FFFFFFF;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic do_clear_a, do_clear_b, do_clear_c, reg_a_sign, reg_b_sign, reg_c_sign;
    logic do_not_a, do_not_b, do_sum, do_and, do_set_c_30;
    logic do_left_shift_b, do_left_shift_c, do_left_shift_c29, do_right_shift_bc;
    logic do_move_c_to_a, do_move_c_to_b, do_move_b_to_c, do_read_mem, do_arr_c, do_load_d;
    logic [W-1:0] mem_rdata, arr_c_data;
    logic [W-1:0] reg_a, reg_b, reg_c, reg_d;
    logic reg_b_0, reg_c_30, reg_d_0, op_conflict;
    int checks = 0;
    int errors = 0;
    logic [W-1:0] ma = '0, mb = '0, mc = '0, md = '0, na, nb, nc, nd;
    logic mconf = 1'b0, nconf;

    always #5 clk = ~clk;

    arith_regs dut (
        .clk(clk), .resetn(resetn),
        .do_clear_a(do_clear_a), .do_clear_b(do_clear_b), .do_clear_c(do_clear_c),
        .reg_a_sign(reg_a_sign), .reg_b_sign(reg_b_sign), .reg_c_sign(reg_c_sign),
        .do_not_a(do_not_a), .do_not_b(do_not_b), .do_sum(do_sum), .do_and(do_and),
        .do_set_c_30(do_set_c_30), .do_left_shift_b(do_left_shift_b),
        .do_left_shift_c(do_left_shift_c), .do_left_shift_c29(do_left_shift_c29),
        .do_right_shift_bc(do_right_shift_bc), .do_move_c_to_a(do_move_c_to_a),
        .do_move_c_to_b(do_move_c_to_b), .do_move_b_to_c(do_move_b_to_c),
        .do_read_mem(do_read_mem), .mem_rdata(mem_rdata),
        .do_arr_c(do_arr_c), .arr_c_data(arr_c_data), .do_load_d(do_load_d),
        .reg_a(reg_a), .reg_b(reg_b), .reg_c(reg_c), .reg_d(reg_d),
        .reg_b_0(reg_b_0), .reg_c_30(reg_c_30), .reg_d_0(reg_d_0),
        .op_conflict(op_conflict)
    );

    function automatic logic [W-1:0] oc_add(input logic [W-1:0] x, input logic [W-1:0] y);
        longint s;
        s = longint'(x) + longint'(y);
        if (s >= 64'h80000000) s = s - 64'h80000000 + 1;
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] lsh(input logic [W-1:0] x, input logic rot);
        logic [W-1:0] m, top;
        m = x & MASK;
        top = (m >> 29) & 31'd1;
        m = (m << 1) & MASK;
        if (rot) m = m | top;
        return (x & ~MASK) | m;
    endfunction

    // Reference: later writers in each list override earlier ones, so lists run lowest priority first.
    task automatic model_step();
        int wa = 0, wb = 0, wc = 0;
        na = ma; nb = mb; nc = mc; nd = md; nconf = mconf;
        if (do_clear_a)     begin na = reg_a_sign ? 31'h40000000 : '0; wa++; end
        if (do_not_a)       begin na = ~ma; wa++; end
        if (do_move_c_to_a) begin na = mc; wa++; end
        if (do_clear_b)        begin nb = reg_b_sign ? 31'h40000000 : '0; wb++; end
        if (do_not_b)          begin nb = ~mb; wb++; end
        if (do_left_shift_b)   begin nb = lsh(mb, 1'b0); wb++; end
        if (do_right_shift_bc) begin nb = (mb & ~MASK) | ((mb & MASK) >> 1); wb++; end
        if (do_move_c_to_b)    begin nb = mc; wb++; end
        if (do_read_mem)       begin nb = mem_rdata; wb++; end
        if (do_clear_c)        begin nc = reg_c_sign ? 31'h40000000 : '0; wc++; end
        if (do_left_shift_c)   begin nc = lsh(mc, do_left_shift_c29); wc++; end
        if (do_right_shift_bc) begin nc = (mc & ~MASK) | ((mb & 31'd1) << 29) | ((mc & MASK) >> 1); wc++; end
        if (do_move_b_to_c)    begin nc = mb; wc++; end
        if (do_and)            begin nc = ma & mb; wc++; end
        if (do_sum)            begin nc = oc_add(ma, mb); wc++; end
        if (do_arr_c)          begin nc = arr_c_data; wc++; end
        if (do_set_c_30) nc = nc | 31'd1;
        if (do_load_d) nd = mem_rdata;
        if (wa > 1 || wb > 1 || wc > 1) nconf = 1'b1;
        if (!resetn) begin na = '0; nb = '0; nc = '0; nd = '0; nconf = 1'b0; end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        ma = na; mb = nb; mc = nc; md = nd; mconf = nconf;
    endtask

    task automatic idle();
        {do_clear_a, do_clear_b, do_clear_c, reg_a_sign, reg_b_sign, reg_c_sign} = '0;
        {do_not_a, do_not_b, do_sum, do_and, do_set_c_30} = '0;
        {do_left_shift_b, do_left_shift_c, do_left_shift_c29, do_right_shift_bc} = '0;
        {do_move_c_to_a, do_move_c_to_b, do_move_b_to_c, do_read_mem, do_arr_c, do_load_d} = '0;
        mem_rdata = '0;
        arr_c_data = '0;
    endtask

    task automatic load(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
        idle();
        arr_c_data = x; do_arr_c = 1'b1;
        cycle();
        idle();
        do_move_c_to_a = 1'b1;
        arr_c_data = z; do_arr_c = 1'b1;
        mem_rdata = y; do_read_mem = 1'b1;
        cycle();
        idle();
    endtask

    task automatic test_reset();
        idle();
        resetn = 1'b0;
        do_arr_c = 1'b1; arr_c_data = 31'h12345678; do_load_d = 1'b1; mem_rdata = 31'h7FFFFFFF;
        cycle();
        checks++;
        if ({reg_a, reg_b, reg_c, reg_d, reg_b_0, reg_c_30, reg_d_0, op_conflict} !== '0) begin
            errors++;
            $display("FAIL reset: a=%h b=%h c=%h d=%h flags=%b%b%b%b, required all 0",
                     reg_a, reg_b, reg_c, reg_d, reg_b_0, reg_c_30, reg_d_0, op_conflict);
        end
        resetn = 1'b1;
        idle();
    endtask

    task automatic test_sum();
        load(31'h7FFFFFFE, 31'h00000003, '0);
        do_sum = 1'b1;
        cycle();
        idle();
        checks++;
        if (reg_c !== 31'h00000002) begin errors++; $display("FAIL sum_c: got %h want 00000002", reg_c); end
        checks++;
        if ({reg_a, reg_b, op_conflict} !== {31'h7FFFFFFE, 31'h00000003, 1'b0}) begin
            errors++; $display("FAIL sum_src: a=%h b=%h conf=%b want 7ffffffe 00000003 0", reg_a, reg_b, op_conflict);
        end
    endtask

    task automatic test_left3();
        logic [W-1:0] exp_c [3] = '{31'h00000003, 31'h00000006, 31'h0000000C};
        load('0, '0, 31'h20000001);
        for (int i = 0; i < 3; i++) begin
            do_left_shift_c = 1'b1; do_left_shift_c29 = 1'b1;
            cycle();
            checks++;
            if ({reg_c, op_conflict} !== {exp_c[i], 1'b0}) begin
                errors++; $display("FAIL left3_%0d: c=%h conf=%b want %h 0", i, reg_c, op_conflict, exp_c[i]);
            end
        end
        idle();
    endtask

    task automatic test_right_shift();
        load('0, 31'h40000001, '0);
        do_right_shift_bc = 1'b1;
        cycle();
        idle();
        checks++;
        if ({reg_b, reg_c, reg_c_30} !== {31'h40000000, 31'h20000000, 1'b0}) begin
            errors++; $display("FAIL right_shift: b=%h c=%h c30=%b want 40000000 20000000 0", reg_b, reg_c, reg_c_30);
        end
    endtask

    task automatic test_and_move();
        load(31'h0F0F0F0F, 31'h00FF00FF, '0);
        do_and = 1'b1;
        cycle();
        idle();
        checks++;
        if (reg_c !== 31'h000F000F) begin errors++; $display("FAIL and: c=%h want 000f000f", reg_c); end
        do_move_c_to_b = 1'b1;
        cycle();
        idle();
        checks++;
        if ({reg_b, reg_b_0} !== {31'h000F000F, 1'b0}) begin
            errors++; $display("FAIL move_c_to_b: b=%h b0=%b want 000f000f 0", reg_b, reg_b_0);
        end
    endtask

    task automatic test_swap_conflict();
        load('0, 31'd1, 31'd2);
        do_move_c_to_b = 1'b1; do_move_b_to_c = 1'b1;
        cycle();
        idle();
        checks++;
        if ({reg_b, reg_c, op_conflict} !== {31'd2, 31'd1, 1'b0}) begin
            errors++; $display("FAIL swap: b=%h c=%h conf=%b want 2 1 0", reg_b, reg_c, op_conflict);
        end
        do_read_mem = 1'b1; mem_rdata = 31'h00000055; do_move_c_to_b = 1'b1;
        cycle();
        idle();
        checks++;
        if ({reg_b, op_conflict} !== {31'h00000055, 1'b1}) begin
            errors++; $display("FAIL conflict: b=%h conf=%b want 00000055 1", reg_b, op_conflict);
        end
        repeat (3) cycle();
        checks++;
        if (op_conflict !== 1'b1) begin errors++; $display("FAIL conflict_sticky: conf=%b want 1", op_conflict); end
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        checks++;
        if (op_conflict !== 1'b0) begin errors++; $display("FAIL conflict_reset: conf=%b want 0", op_conflict); end
    endtask

    task automatic test_reset_mid_op();
        load(31'h7FFFFFFE, 31'h00000003, 31'h5);
        do_load_d = 1'b1; mem_rdata = 31'h40000000;
        cycle();
        idle();
        do_sum = 1'b1; resetn = 1'b0;
        cycle();
        idle();
        resetn = 1'b1;
        checks++;
        if ({reg_a, reg_b, reg_c, reg_d, op_conflict} !== '0) begin
            errors++; $display("FAIL reset_mid_op: a=%h b=%h c=%h d=%h conf=%b want all 0",
                               reg_a, reg_b, reg_c, reg_d, op_conflict);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            {do_clear_a, do_clear_b, do_clear_c} = {$urandom_range(0,5) == 0, $urandom_range(0,5) == 0, $urandom_range(0,5) == 0};
            {reg_a_sign, reg_b_sign, reg_c_sign} = 3'($urandom());
            do_not_a = $urandom_range(0,5) == 0;
            do_not_b = $urandom_range(0,5) == 0;
            do_sum = $urandom_range(0,5) == 0;
            do_and = $urandom_range(0,5) == 0;
            do_set_c_30 = $urandom_range(0,5) == 0;
            do_left_shift_b = $urandom_range(0,5) == 0;
            do_left_shift_c = $urandom_range(0,4) == 0;
            do_left_shift_c29 = $urandom_range(0,2) == 0;
            do_right_shift_bc = $urandom_range(0,5) == 0;
            do_move_c_to_a = $urandom_range(0,5) == 0;
            do_move_c_to_b = $urandom_range(0,5) == 0;
            do_move_b_to_c = $urandom_range(0,5) == 0;
            do_read_mem = $urandom_range(0,5) == 0;
            do_arr_c = $urandom_range(0,5) == 0;
            do_load_d = $urandom_range(0,4) == 0;
            mem_rdata = W'($urandom());
            arr_c_data = W'($urandom());
            resetn = $urandom_range(0,24) != 0;
            cycle();
            checks++;
            if ({reg_a, reg_b, reg_c, reg_d, op_conflict, reg_b_0, reg_c_30, reg_d_0} !==
                {ma, mb, mc, md, mconf, mb[W-1], mc[0], md[W-1]}) begin
                errors++;
                $display("FAIL random_%0d: got a=%h b=%h c=%h d=%h conf=%b flags=%b%b%b want a=%h b=%h c=%h d=%h conf=%b",
                         i, reg_a, reg_b, reg_c, reg_d, op_conflict, reg_b_0, reg_c_30, reg_d_0,
                         ma, mb, mc, md, mconf);
            end
        end
        resetn = 1'b1;
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_sum();
        test_left3();
        test_right_shift();
        test_and_move();
        test_swap_conflict();
        test_reset_mid_op();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
